// File: rtl/wb_regfile_if.sv
// EX/WB writeback, decode read-port and EX forwarding signals of wb_regfile.
// master drives the pipeline-side inputs; slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_ext_data;
    logic [DATA_W-1:0] wb_aluout;
    logic              wb_regwrite;
    logic              wb_wbsel;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] ex_rs1;
    logic [ADDR_W-1:0] ex_rs2;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output wb_rd, wb_ext_data, wb_aluout, wb_regwrite, wb_wbsel,
        output rd_addr1, rd_addr2, ex_rs1, ex_rs2,
        input  rd_data1, rd_data2, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2,
        input  wb_data, wr_count
    );

    modport slave (
        input  wb_rd, wb_ext_data, wb_aluout, wb_regwrite, wb_wbsel,
        input  rd_addr1, rd_addr2, ex_rs1, ex_rs2,
        output rd_data1, rd_data2, fwd_sel1, fwd_sel2, fwd_data1, fwd_data2,
        output wb_data, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file with two read ports, two-level EX forwarding and a write counter.
// Optional macro WB_BYPASS_EN: same-cycle write-through onto the read ports.
module wb_regfile #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic        LP_R0 = (R0_ZERO != 0);

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_CUR  = 2'b01,
        FWD_PREV = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        fwd_sel_e          sel;
        logic [DATA_W-1:0] data;
    } fwd_t;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_prev_valid;
    logic [ADDR_W-1:0] r_prev_rd;
    logic [DATA_W-1:0] r_prev_data;
    logic [CNT_W-1:0]  r_wr_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    fwd_t              w_fwd1;
    fwd_t              w_fwd2;

    // Current WB beats the previous WB stage; R0 never forwards when hard-wired.
    function automatic fwd_t f_fwd(
        input logic [ADDR_W-1:0] rs,
        input logic              we,
        input logic [ADDR_W-1:0] wr_rd,
        input logic [DATA_W-1:0] wr_data,
        input logic              pv,
        input logic [ADDR_W-1:0] p_rd,
        input logic [DATA_W-1:0] p_data
    );
        fwd_t f;
        f.sel  = FWD_NONE;
        f.data = '0;
        if (!(LP_R0 && rs == '0)) begin
            if (we && wr_rd == rs) begin
                f.sel  = FWD_CUR;
                f.data = wr_data;
            end else if (pv && p_rd == rs) begin
                f.sel  = FWD_PREV;
                f.data = p_data;
            end
        end
        return f;
    endfunction

    always_comb begin
        w_wb_data = bus.wb_wbsel ? bus.wb_ext_data : bus.wb_aluout;
        w_we      = bus.wb_regwrite & ~(LP_R0 & (bus.wb_rd == '0));
    end

    always_comb begin
        w_rd_data1 = r_regs[bus.rd_addr1];
        w_rd_data2 = r_regs[bus.rd_addr2];
`ifdef WB_BYPASS_EN
        if (w_we && bus.rd_addr1 == bus.wb_rd) w_rd_data1 = w_wb_data;
        if (w_we && bus.rd_addr2 == bus.wb_rd) w_rd_data2 = w_wb_data;
`endif
        if (LP_R0 && bus.rd_addr1 == '0) w_rd_data1 = '0;
        if (LP_R0 && bus.rd_addr2 == '0) w_rd_data2 = '0;
    end

    always_comb begin
        w_fwd1 = f_fwd(bus.ex_rs1, w_we, bus.wb_rd, w_wb_data,
                       r_prev_valid, r_prev_rd, r_prev_data);
        w_fwd2 = f_fwd(bus.ex_rs2, w_we, bus.wb_rd, w_wb_data,
                       r_prev_valid, r_prev_rd, r_prev_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regs       <= '{default: '0};
            r_prev_valid <= 1'b0;
            r_prev_rd    <= '0;
            r_prev_data  <= '0;
            r_wr_count   <= '0;
        end else begin
            if (w_we) begin
                r_regs[bus.wb_rd] <= w_wb_data;
                if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
            end
            r_prev_valid <= w_we;
            r_prev_rd    <= bus.wb_rd;
            r_prev_data  <= w_wb_data;
        end
    end

    assign bus.wb_data   = w_wb_data;
    assign bus.rd_data1  = w_rd_data1;
    assign bus.rd_data2  = w_rd_data2;
    assign bus.fwd_sel1  = w_fwd1.sel;
    assign bus.fwd_sel2  = w_fwd2.sel;
    assign bus.fwd_data1 = w_fwd1.data;
    assign bus.fwd_data2 = w_fwd2.data;
    assign bus.wr_count  = r_wr_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: two instances (CNT_W=16 and CNT_W=4) share one stimulus stream.
// The reference model follows WB_BYPASS_EN the same way the build does.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] t_rd = '0, t_a1 = '0, t_a2 = '0, t_s1 = '0, t_s2 = '0;
    logic [7:0] t_ext = '0, t_alu = '0;
    logic       t_rw = 1'b0, t_sel = 1'b0;

    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus ();
    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(4))  bus_s ();

    wb_regfile #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    wb_regfile #(.DATA_W(8), .ADDR_W(3), .R0_ZERO(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s));

    assign bus.wb_rd = t_rd;          assign bus_s.wb_rd = t_rd;
    assign bus.wb_ext_data = t_ext;   assign bus_s.wb_ext_data = t_ext;
    assign bus.wb_aluout = t_alu;     assign bus_s.wb_aluout = t_alu;
    assign bus.wb_regwrite = t_rw;    assign bus_s.wb_regwrite = t_rw;
    assign bus.wb_wbsel = t_sel;      assign bus_s.wb_wbsel = t_sel;
    assign bus.rd_addr1 = t_a1;       assign bus_s.rd_addr1 = t_a1;
    assign bus.rd_addr2 = t_a2;       assign bus_s.rd_addr2 = t_a2;
    assign bus.ex_rs1 = t_s1;         assign bus_s.ex_rs1 = t_s1;
    assign bus.ex_rs2 = t_s2;         assign bus_s.ex_rs2 = t_s2;

    typedef struct {
        logic [7:0] rd1, rd2, f1d, f2d, wbd;
        logic [1:0] f1s, f2s;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        string       tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference state: plain array, previous-writeback record, unbounded write tally.
    logic [7:0] m_regs [8];
    bit         m_pv;
    logic [2:0] m_prd;
    logic [7:0] m_pd;
    int         m_cnt;

    function automatic logic [7:0] m_read(input logic [2:0] a, input bit we,
                                          input logic [2:0] rd, input logic [7:0] wbd);
        if (a == 0) return 8'h00;
`ifdef WB_BYPASS_EN
        if (we && a == rd) return wbd;
`endif
        return m_regs[a];
    endfunction

    task automatic m_fwd(input logic [2:0] rs, input bit we, input logic [2:0] rd,
                         input logic [7:0] wbd, output logic [1:0] s, output logic [7:0] d);
        s = 2'b00; d = 8'h00;
        if (rs == 0) return;
        if (we && rs == rd) begin s = 2'b01; d = wbd; end
        else if (m_pv && rs == m_prd) begin s = 2'b10; d = m_pd; end
    endtask

    task automatic cyc(input bit r, input logic [2:0] rd, input logic [7:0] ext, input logic [7:0] alu,
                       input bit rw, input bit sel, input logic [2:0] a1, input logic [2:0] a2,
                       input logic [2:0] s1, input logic [2:0] s2, input string tag);
        exp_t e;
        logic [7:0] wbd;
        bit we;
        @(posedge clk); #1;
        rst = r; t_rd = rd; t_ext = ext; t_alu = alu; t_rw = rw; t_sel = sel;
        t_a1 = a1; t_a2 = a2; t_s1 = s1; t_s2 = s2;
        if (!r) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_pv = 0; m_prd = 0; m_pd = 0; m_cnt = 0;
        end
        wbd = sel ? ext : alu;
        we  = rw && (rd != 0);
        e.tag = tag;
        e.wbd = wbd;
        e.rd1 = m_read(a1, we, rd, wbd);
        e.rd2 = m_read(a2, we, rd, wbd);
        m_fwd(s1, we, rd, wbd, e.f1s, e.f1d);
        m_fwd(s2, we, rd, wbd, e.f2s, e.f2d);
        e.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        q.push_back(e);
        if (r) begin
            if (we) begin m_regs[rd] = wbd; m_cnt++; end
            m_pv = we; m_prd = rd; m_pd = wbd;
        end
    endtask

    task automatic chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h want %h", tag, name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "wb_data",   16'(bus.wb_data),   16'(e.wbd));
                chk(e.tag, "rd_data1",  16'(bus.rd_data1),  16'(e.rd1));
                chk(e.tag, "rd_data2",  16'(bus.rd_data2),  16'(e.rd2));
                chk(e.tag, "fwd_sel1",  16'(bus.fwd_sel1),  16'(e.f1s));
                chk(e.tag, "fwd_sel2",  16'(bus.fwd_sel2),  16'(e.f2s));
                chk(e.tag, "fwd_data1", 16'(bus.fwd_data1), 16'(e.f1d));
                chk(e.tag, "fwd_data2", 16'(bus.fwd_data2), 16'(e.f2d));
                chk(e.tag, "wr_count",  bus.wr_count,       e.cnt);
                chk(e.tag, "s.rd_data1", 16'(bus_s.rd_data1), 16'(e.rd1));
                chk(e.tag, "s.rd_data2", 16'(bus_s.rd_data2), 16'(e.rd2));
                chk(e.tag, "s.fwd_sel1", 16'(bus_s.fwd_sel1), 16'(e.f1s));
                chk(e.tag, "s.fwd_sel2", 16'(bus_s.fwd_sel2), 16'(e.f2s));
                chk(e.tag, "s.fwd_data1", 16'(bus_s.fwd_data1), 16'(e.f1d));
                chk(e.tag, "s.fwd_data2", 16'(bus_s.fwd_data2), 16'(e.f2d));
                chk(e.tag, "s.wb_data", 16'(bus_s.wb_data), 16'(e.wbd));
                chk(e.tag, "s.wr_count", 16'(bus_s.wr_count), 16'(e.cnt4));
            end
        end
    end

    initial begin : stim
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_pv = 0; m_prd = 0; m_pd = 0; m_cnt = 0;

        cyc(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, "reset");
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 1, 2, 1, 2, "reset");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 8'h00, 8'h00, 0, 0, 3'(i), 3'(7 - i), 3'(i), 3'(7 - i), "post_reset");

        cyc(1, 3, 8'hC3, 8'h5A, 1, 0, 3, 3, 3, 0, "wbsel0");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 3, 0, 0, 0, "wbsel0_rd");
        cyc(1, 3, 8'hC3, 8'h5A, 1, 1, 3, 3, 0, 3, "wbsel1");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 3, 3, 0, 0, "wbsel1_rd");

        cyc(1, 0, 8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, "r0_write");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, "r0_after");

        cyc(1, 2, 8'h00, 8'h11, 1, 0, 0, 0, 2, 0, "fwd_cur");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2, 0, "fwd_prev");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2, 0, "fwd_none");
        cyc(1, 2, 8'h00, 8'h11, 1, 0, 0, 0, 2, 2, "b2b_first");
        cyc(1, 2, 8'h00, 8'h22, 1, 0, 0, 0, 2, 2, "b2b_second");

        cyc(1, 5, 8'h00, 8'h7E, 1, 0, 5, 5, 0, 0, "bypass");
        cyc(1, 0, 8'h00, 8'h00, 0, 0, 5, 5, 0, 0, "bypass_next");

        for (int i = 0; i < 20; i++)
            cyc(1, 3'(1 + i % 7), 8'h00, 8'(i * 13), 1, 0, 3'(i % 8), 3'(1 + i % 7), 3'(1 + i % 7), 3'(i % 8), "saturate");

        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 9) < 7), 1'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");

        cyc(1, 4, 8'h00, 8'h44, 1, 0, 4, 4, 4, 4, "pre_rst");
        cyc(0, 6, 8'h00, 8'h66, 1, 0, 4, 6, 4, 0, "rst_mid_write");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 8'h00, 8'h00, 0, 0, 3'(i), 3'(i), 3'(i), 3'(i), "after_rst");

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
